// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract arbiter slice.
package addsub_pkg;

  localparam int W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the result consumer.
interface addsub_arbiter_if #(
  parameter int W = 4
);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic mode0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic mode1;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_id;
  logic [W:0] rsp_result;
  logic busy;

  modport master (
    output req_valid, a0, b0, mode0, a1, b1, mode1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req_valid, a0, b0, mode0, a1, b1, mode1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/addsub4.sv
// Combinational W-bit ripple add/subtract; in subtract mode bit W is the sign of a-b.
module addsub4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic [W:0]   result
);
  logic [W:0]   carry;
  logic [W-1:0] b_x;
  logic [W-1:0] sum;

  // Subtract is a + ~b + 1: invert b and inject the +1 as carry-in.
  assign carry[0] = mode;
  assign b_x      = b ^ {W{mode}};

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_x[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign result = {carry[W] ^ mode, sum};
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that sequences two requesters through one shared add/subtract unit.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int W = addsub_pkg::W
) (
  input  logic       clk,
  input  logic       reset,
  addsub_arbiter_if.slave bus
);
  state_t       state_q;
  state_t       state_d;
  logic         last_grant_q;
  logic         gnt;
  logic         accept;
  logic [1:0]   req_ready;

  logic [W-1:0] a_p0;
  logic [W-1:0] b_p0;
  logic         mode_p0;
  logic         id_p0;
  logic [W:0]   sum_p0;

  logic [W:0]   rsp_result_p1;
  logic         rsp_id_p1;
  logic         rsp_valid_p1;

  // Grant depends only on req_valid and state, never on operands.
  always_comb begin
    state_d   = state_q;
    gnt       = 1'b0;
    req_ready = 2'b00;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (bus.req_valid)
          2'b01:   gnt = 1'b0;
          2'b10:   gnt = 1'b1;
          2'b11:   gnt = ~last_grant_q;
          default: gnt = 1'b0;
        endcase
        if (|bus.req_valid) begin
          accept    = 1'b1;
          req_ready = gnt ? 2'b10 : 2'b01;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: operand register loaded on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_p0         <= '0;
      b_p0         <= '0;
      mode_p0      <= 1'b0;
      id_p0        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_p0    <= gnt ? bus.a1 : bus.a0;
        b_p0    <= gnt ? bus.b1 : bus.b0;
        mode_p0 <= gnt ? bus.mode1 : bus.mode0;
        id_p0   <= gnt;
      end
      if (state_q == EXEC) last_grant_q <= id_p0;
    end
  end

  addsub4 #(.W(W)) u_addsub (
    .a      (a_p0),
    .b      (b_p0),
    .mode   (mode_p0),
    .result (sum_p0)
  );

  // Stage p1: registered response, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_result_p1 <= '0;
      rsp_id_p1     <= 1'b0;
      rsp_valid_p1  <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_result_p1 <= sum_p0;
      rsp_id_p1     <= id_p0;
      rsp_valid_p1  <= 1'b1;
    end else if (state_q == RESP && bus.rsp_ready) begin
      rsp_valid_p1  <= 1'b0;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_p1;
  assign bus.rsp_result = rsp_result_p1;
  assign bus.rsp_id     = rsp_id_p1;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ripple add/subtract datapath. It accepts operations from two independent requesters over valid/ready handshakes and grants them round-robin. It drives each accepted operation through one add/subtract unit, registers the 5-bit result, and returns it with the requester ID over a valid/ready response channel. It sits between the lab's input-capture logic and the display/result path.

## Interface
Parameters:
- W, 4, operand width; result width is W+1.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: requester i's operation is accepted this cycle; at most one bit high.
- a0, b0  in  W each  requester 0 operands, unsigned.
- mode0  in  1  requester 0 op: 0 = add, 1 = subtract.
- a1, b1  in  W each  requester 1 operands, unsigned.
- mode1  in  1  requester 1 op: 0 = add, 1 = subtract.
- rsp_valid  out  1  response holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  W+1  result.
- busy  out  1  high in every state except IDLE.

## Operation
State machine has three states: IDLE, EXEC and RESP.

- **IDLE**
  - If no req_valid bit is set, stay in IDLE.
  - If exactly one bit is set, grant that requester.
  - If both bits are set, grant the requester that is not last_grant.
  - The grant drives req_ready[g]=1 combinationally in the same cycle.
  - Latch a/b/mode of the granted requester and its ID into the operand register, then go to EXEC.
- **EXEC**
  - The latched operands drive the addsub4 instance.
  - Register the result into rsp_result and the ID into rsp_id.
  - Set last_grant to g and go to RESP.
- **RESP**
  - rsp_valid=1; rsp_result and rsp_id are held stable.
  - When rsp_ready=1, go to IDLE; rsp_valid falls the next cycle.
  - If rsp_ready=0, stay in RESP indefinitely.
- **Arithmetic**
  - Add: rsp_result = {0,a} + {0,b}, unsigned, range 0..30; bit 4 is the carry.
  - Subtract: rsp_result = a + ~b + 1 over 5 bits, which is a−b in two's complement, range −15..15.
    - Bit 4 is the sign, equal to the inverted carry-out.
    - Example: 3−5 = 5'b11110.
- **Requests while busy:** req_ready stays 0 in EXEC and RESP. Requesters must hold valid and operands until ready; the arbiter never drops a waiting request.
- **Requester fairness:** a requester that continuously asserts valid waits at most one other operation.
- **Reset**
  - Values: state=IDLE, last_grant=1 (requester 0 wins the first tie), rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, operand register cleared.
  - Reset mid-EXEC or mid-RESP discards the in-flight operation; no response is produced for it.

## Timing
- Request accepted at edge N (req_ready high in cycle N) → result registered at edge N+1 → rsp_valid high from cycle N+2.
- Minimum spacing between accepts is 3 cycles when rsp_ready is held high (IDLE, EXEC, RESP).
- req_ready depends combinationally on req_valid and the state only; it never depends on operand values.
- rsp_* outputs are registered; there is no combinational path from inputs to rsp_*.

## Structure
- **Package addsub_pkg:**
  - state enum (IDLE, EXEC, RESP);
  - OP_ADD=0 and OP_SUB=1 constants;
  - default width W=4.
- **Sub-module addsub4:**
  - combinational W-bit ripple add/subtract;
  - XOR b with mode; carry-in = mode; bit 4 = carry XOR mode;
  - built from the existing full_adder cells.
- **addsub_arbiter itself:** contains only the FSM, round-robin pointer, operand/result registers and handshakes.

## Test plan
- Reset, then req_valid=01 with a0=9, b0=7, mode0=0 → req_ready=01 in the same cycle; rsp_valid two cycles later with rsp_result=16, rsp_id=0.
- req_valid=10 with a1=3, b1=5, mode1=1 → rsp_result=5'b11110, rsp_id=1; with a1=15, b1=15, mode1=1 → 0.
- Both valid continuously after reset for four operations → grant order 0,1,0,1; req_ready never 11.
- Hold rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_result and rsp_id stay stable and req_ready stays 00; releasing rsp_ready returns to IDLE the next cycle.
- Assert reset in EXEC and again in RESP → next cycle all outputs are at reset values and no response appears for the discarded operation.
- Exhaustive 256×2 operand/mode sweep through requester 0 → every rsp_result matches the golden add / two's-complement subtract.
